// File: rtl/uart_rx_oversampler_if.sv
// Receiver-side bundle: serial line in, received byte out through a
// one-entry valid/ready holding register, plus status pulses.
interface uart_rx_oversampler_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 framing_error;
    logic                 overrun;
    logic                 busy;

    // Receiver side.
    modport slave (
        input  rxd, data_ready,
        output data, data_valid, framing_error, overrun, busy
    );

    // Line driver / byte consumer side.
    modport master (
        output rxd, data_ready,
        input  data, data_valid, framing_error, overrun, busy
    );
endinterface

// File: rtl/uart_rx_oversampler.sv
// UART receiver: 2-flop input synchronizer, clock-count baud timer that
// samples mid-bit, idle/start/data/stop/wait-idle FSM, and a one-entry
// holding register with framing-error and overrun pulses.
module uart_rx_oversampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_oversampler_if.slave  rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 rxd_s;
    logic                 stop_ok;
    logic                 accept;

    assign rxd_s  = sync_q[1];
    assign accept = valid_q & rx.data_ready;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, making the chain a real two-stage delay.
            sync_q <= {sync_q[0], rx.rxd};
        end
    end

    // FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: counter restarts on every state change, sampling at mid-bit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_ok = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxd_s;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        stop_ok = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must not decode as a stream of zero bytes.
                if (rxd_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: accept/reload in one cycle is not an overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (stop_ok) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Output registers: holding register and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.data          = data_q;
    assign rx.data_valid    = valid_q;
    assign rx.framing_error = fe_q;
    assign rx.overrun       = ovr_q;
    assign rx.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: a default instance (16 clk/bit, 8 bits)
// and a corner instance (4 clk/bit, 5 bits). Expected bytes are queued
// as frames are sent; a monitor pops and compares on each accepted byte.
module tb_uart_rx_oversampler;
    localparam int CPB_A = 16;
    localparam int DB_A  = 8;
    localparam int CPB_B = 4;
    localparam int DB_B  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_oversampler_if #(.DATA_BITS(DB_A)) if_a ();
    uart_rx_oversampler_if #(.DATA_BITS(DB_B)) if_b ();

    uart_rx_oversampler #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .rx  (if_a)
    );

    uart_rx_oversampler #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .rx  (if_b)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int fe_a   = 0;
    int ov_a   = 0;
    int fe_b   = 0;
    int ov_b   = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count status pulses and score every accepted byte.
    always @(negedge clk) begin
        if (rst) begin
            if (if_a.framing_error) fe_a++;
            if (if_a.overrun)       ov_a++;
            if (if_b.framing_error) fe_b++;
            if (if_b.overrun)       ov_b++;
            if (if_a.data_valid && if_a.data_ready) begin
                if (exp_a.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb_a_unexpected: got 0x%0h, expected no byte", if_a.data);
                end else begin
                    check("sb_a_data", 32'(if_a.data), 32'(exp_a.pop_front()));
                end
            end
            if (if_b.data_valid && if_b.data_ready) begin
                if (exp_b.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb_b_unexpected: got 0x%0h, expected no byte", if_b.data);
                end else begin
                    check("sb_b_data", 32'(if_b.data), 32'(exp_b.pop_front()[DB_B-1:0]));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) if_b.rxd = v;
        else     if_a.rxd = v;
    endtask

    // Sends one frame; starts and ends 1 time unit after a rising edge.
    task automatic send(input bit sel, input logic [7:0] val, input logic stop_bit);
        int cpb;
        int db;
        cpb = sel ? CPB_B : CPB_A;
        db  = sel ? DB_B  : DB_A;
        drive(sel, 1'b0);
        idle(cpb);
        for (int k = 0; k < db; k++) begin
            drive(sel, val[k]);
            idle(cpb);
        end
        drive(sel, stop_bit);
        idle(cpb);
    endtask

    task automatic pulse_ready(input bit sel);
        if (sel) if_b.data_ready = 1'b1;
        else     if_a.data_ready = 1'b1;
        idle(1);
        if_a.data_ready = 1'b0;
        if_b.data_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.rxd = 1'b1;
        if_a.data_ready = 1'b0;
        if_b.rxd = 1'b1;
        if_b.data_ready = 1'b0;

        // Reset state
        idle(3);
        check("rst_valid", 32'(if_a.data_valid), 0);
        check("rst_busy",  32'(if_a.busy), 0);
        check("rst_data",  32'(if_a.data), 0);
        check("rst_fe",    32'(if_a.framing_error), 0);
        check("rst_ovr",   32'(if_a.overrun), 0);
        rst = 1'b1;
        idle(5);

        // Basic frame 0xA5 with exact delivery latency
        exp_a.push_back(8'hA5);
        fork
            send(0, 8'hA5, 1'b1);
            begin
                idle(CPB_A/2 + (DB_A + 1) * CPB_A + 2);
                check("basic_valid_early", 32'(if_a.data_valid), 0);
                idle(1);
                check("basic_valid_on_time", 32'(if_a.data_valid), 1);
                check("basic_data", 32'(if_a.data), 32'h A5);
            end
        join
        idle(20);
        check("basic_valid_held", 32'(if_a.data_valid), 1);
        pulse_ready(0);
        check("basic_valid_clear", 32'(if_a.data_valid), 0);
        idle(5);

        // Start-bit glitch
        if_a.rxd = 1'b0;
        idle(4);
        if_a.rxd = 1'b1;
        check("glitch_busy_rise", 32'(if_a.busy), 1);
        idle(20);
        check("glitch_busy_fall", 32'(if_a.busy), 0);
        check("glitch_no_valid",  32'(if_a.data_valid), 0);
        check("glitch_no_fe",     32'(fe_a), 0);

        // Framing error, break held low, then recovery with 0x81
        send(0, 8'h3C, 1'b0);
        idle(40);
        check("fe_pulse_count", 32'(fe_a), 1);
        check("fe_wait_busy",   32'(if_a.busy), 1);
        check("fe_no_valid",    32'(if_a.data_valid), 0);
        if_a.rxd = 1'b1;
        idle(5);
        check("fe_back_idle", 32'(if_a.busy), 0);
        exp_a.push_back(8'h81);
        send(0, 8'h81, 1'b1);
        idle(5);
        check("fe_recover_valid", 32'(if_a.data_valid), 1);
        check("fe_recover_data",  32'(if_a.data), 32'h81);
        pulse_ready(0);
        check("fe_pulse_final", 32'(fe_a), 1);

        // Overrun: 0x22 dropped while 0x11 is held
        exp_a.push_back(8'h11);
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        idle(5);
        check("ovr_pulse_count", 32'(ov_a), 1);
        check("ovr_hold_data",   32'(if_a.data), 32'h11);
        check("ovr_hold_valid",  32'(if_a.data_valid), 1);

        // 0x33 arrives while 0x11 is accepted in the same cycle
        exp_a.push_back(8'h33);
        fork
            send(0, 8'h33, 1'b1);
            begin
                idle(CPB_A/2 + (DB_A + 1) * CPB_A + 2);
                pulse_ready(0);
                check("reload_valid", 32'(if_a.data_valid), 1);
                check("reload_data",  32'(if_a.data), 32'h33);
            end
        join
        idle(3);
        check("reload_no_ovr", 32'(ov_a), 1);
        pulse_ready(0);

        // Reset mid-frame with a byte still held
        send(0, 8'h44, 1'b1);
        idle(3);
        check("pre_rst_valid", 32'(if_a.data_valid), 1);
        fork
            send(0, 8'hFF, 1'b1);
            begin
                idle(5 * CPB_A + 5);
                #2;
                rst = 1'b0;
                #1;
                check("midrst_valid", 32'(if_a.data_valid), 0);
                check("midrst_data",  32'(if_a.data), 0);
                check("midrst_busy",  32'(if_a.busy), 0);
                check("midrst_fe",    32'(if_a.framing_error), 0);
                check("midrst_ovr",   32'(if_a.overrun), 0);
                idle(4);
                rst = 1'b1;
            end
        join
        idle(5);
        check("postrst_no_valid", 32'(if_a.data_valid), 0);
        exp_a.push_back(8'h5A);
        send(0, 8'h5A, 1'b1);
        idle(3);
        check("postrst_data", 32'(if_a.data), 32'h5A);
        pulse_ready(0);

        // Corner instance: 4 clk/bit, 5 data bits
        exp_b.push_back(8'h15);
        fork
            send(1, 8'h15, 1'b1);
            begin
                idle(CPB_B/2 + (DB_B + 1) * CPB_B + 2);
                check("corner_valid_early", 32'(if_b.data_valid), 0);
                idle(1);
                check("corner_valid_on_time", 32'(if_b.data_valid), 1);
                check("corner_data", 32'(if_b.data), 32'h15);
            end
        join
        pulse_ready(1);
        exp_b.push_back(8'h0A);
        send(1, 8'h0A, 1'b1);
        idle(3);
        pulse_ready(1);
        check("corner_no_fe",  32'(fe_b), 0);
        check("corner_no_ovr", 32'(ov_b), 0);

        idle(5);
        check("sb_a_drained", 32'(exp_a.size()), 0);
        check("sb_b_drained", 32'(exp_b.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
